// File: rtl/packet_buffer_pkg.sv
// packet_buffer_pkg
//   Shared defaults and types for the packet_buffer slice.
//   AXI_WIDTH_DEFAULT    ingress beat width in bits
//   OUTPUT_WIDTH_DEFAULT egress lane width in bits
//   DEPTH_DEFAULT        FIFO depth in beats
//   lane_t               one egress byte lane
//   is_pow2()            true for powers of two that are at least 2
package packet_buffer_pkg;

  localparam int AXI_WIDTH_DEFAULT    = 64;
  localparam int OUTPUT_WIDTH_DEFAULT = 8;
  localparam int DEPTH_DEFAULT        = 16;

  typedef logic [7:0] lane_t;

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/packet_buffer_sync_fifo.sv
// sync_fifo
//   Single-clock first-word-fall-through FIFO. The head entry is always
//   presented on head; it is meaningful only while empty is low.
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low (clears pointers and count)
//   push       write request, ignored while full
//   push_data  data written on push
//   pop        read request, ignored while empty
//   head       oldest stored entry
//   full       count == DEPTH
//   empty      count == 0
module sync_fifo
  import packet_buffer_pkg::*;
#(
  parameter int WIDTH = AXI_WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr;
  logic             rd;

  // Full blocks a write even when a read happens in the same cycle:
  // there is no bypass path around the storage.
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr, rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/packet_buffer.sv
// packet_buffer
//   Elastic store between a full-width valid/ready ingress and a
//   lane-parallel egress. Each stored beat leaves as NUM_LANES lanes
//   under one valid/ready pair; lane 0 carries the least significant bits.
//   clk_i         rising-edge clock
//   rst_ni        synchronous reset, active-low
//   tdata_i       ingress beat
//   tvalid_i      ingress valid
//   tready_o      ingress ready (not full, low during reset)
//   pkt_tdata_o   egress lanes, zero while pkt_tvalid_o is low
//   pkt_tvalid_o  egress valid (not empty, low during reset)
//   pkt_tready_i  egress ready
module packet_buffer
  import packet_buffer_pkg::*;
#(
  parameter  int AXI_WIDTH    = AXI_WIDTH_DEFAULT,
  parameter  int OUTPUT_WIDTH = OUTPUT_WIDTH_DEFAULT,
  parameter  int DEPTH        = DEPTH_DEFAULT,
  localparam int NUM_LANES    = AXI_WIDTH / OUTPUT_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [AXI_WIDTH-1:0]    tdata_i,
  input  logic                    tvalid_i,
  output logic                    tready_o,
  output logic [OUTPUT_WIDTH-1:0] pkt_tdata_o [NUM_LANES],
  output logic                    pkt_tvalid_o,
  input  logic                    pkt_tready_i
);

  if ((AXI_WIDTH % OUTPUT_WIDTH) != 0) begin : g_bad_width
    $error("packet_buffer: AXI_WIDTH must be a multiple of OUTPUT_WIDTH");
  end
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("packet_buffer: DEPTH must be a power of two, at least 2");
  end

  logic [AXI_WIDTH-1:0] head;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  // Handshakes depend only on registered FIFO state and the reset pin,
  // so nothing on the ingress side reaches the outputs combinationally.
  assign tready_o     = rst_ni && !full;
  assign pkt_tvalid_o = rst_ni && !empty;
  assign push         = tvalid_i && tready_o;
  assign pop          = pkt_tvalid_o && pkt_tready_i;

  sync_fifo #(
    .WIDTH (AXI_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (push),
    .push_data (tdata_i),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign pkt_tdata_o[i] = pkt_tvalid_o ? head[i*OUTPUT_WIDTH +: OUTPUT_WIDTH] : '0;
  end

endmodule

// File: tb/tb_packet_buffer.sv
module tb_packet_buffer;
  import packet_buffer_pkg::*;

  logic        clk_i;
  logic        rst_ni;
  logic [63:0] tdata_i;
  logic        tvalid_i;
  logic        tready_o;
  lane_t       pkt_tdata_o [8];
  logic        pkt_tvalid_o;
  logic        pkt_tready_i;

  packet_buffer #(
    .AXI_WIDTH    (64),
    .OUTPUT_WIDTH (8),
    .DEPTH        (16)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .tdata_i      (tdata_i),
    .tvalid_i     (tvalid_i),
    .tready_o     (tready_o),
    .pkt_tdata_o  (pkt_tdata_o),
    .pkt_tvalid_o (pkt_tvalid_o),
    .pkt_tready_i (pkt_tready_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int          n_chk = 0;
  int          n_bad = 0;
  int          pops  = 0;
  int          pushes = 0;
  logic [63:0] sb_q [$];
  logic        hold_vld = 1'b0;
  logic [63:0] hold_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] lanes();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = pkt_tdata_o[i];
    return r;
  endfunction

  // Called right after a falling edge with inputs already driven.
  // Scores the handshakes that the coming rising edge will complete.
  task automatic cycle();
    logic [63:0] exp;
    #1;
    if (hold_vld && pkt_tvalid_o) chk("stable", lanes(), hold_data);
    hold_vld  = pkt_tvalid_o && !pkt_tready_i;
    hold_data = lanes();
    if (pkt_tvalid_o && pkt_tready_i) begin
      if (sb_q.size() == 0) begin
        chk("pop_unexpected", 64'd1, 64'd0);
      end else begin
        exp = sb_q.pop_front();
        chk("pop_data", lanes(), exp);
      end
      pops++;
    end
    if (tvalid_i && tready_o) begin
      sb_q.push_back(tdata_i);
      pushes++;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    tvalid_i     = 1'b0;
    pkt_tready_i = 1'b1;
    while (sb_q.size() > 0 && guard < 100) begin
      cycle();
      guard++;
    end
    chk(tag, 64'(sb_q.size()), 64'd0);
    chk({tag, "_vld"}, 64'(pkt_tvalid_o), 64'd0);
  endtask

  initial begin
    rst_ni       = 1'b0;
    tdata_i      = '0;
    tvalid_i     = 1'b0;
    pkt_tready_i = 1'b0;

    // reset
    @(negedge clk_i);
    cycle();
    chk("rst_rdy", 64'(tready_o), 64'd0);
    chk("rst_vld", 64'(pkt_tvalid_o), 64'd0);
    chk("rst_data", lanes(), 64'd0);
    rst_ni = 1'b1;
    #1;
    chk("rel_rdy", 64'(tready_o), 64'd1);
    chk("rel_vld", 64'(pkt_tvalid_o), 64'd0);

    // single beat, lane mapping
    tdata_i      = 64'h0706050403020100;
    tvalid_i     = 1'b1;
    pkt_tready_i = 1'b1;
    cycle();
    tvalid_i = 1'b0;
    chk("one_vld", 64'(pkt_tvalid_o), 64'd1);
    for (int i = 0; i < 8; i++) chk($sformatf("lane%0d", i), 64'(pkt_tdata_o[i]), 64'(i));
    cycle();
    chk("one_empty", 64'(pkt_tvalid_o), 64'd0);

    // fill to full with egress stalled
    pops = 0;
    pkt_tready_i = 1'b0;
    tvalid_i     = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tdata_i = 64'(k);
      chk("fill_rdy", 64'(tready_o), 64'd1);
      cycle();
    end
    tdata_i = 64'd17;
    chk("full_rdy", 64'(tready_o), 64'd0);
    pkt_tready_i = 1'b1;
    cycle();
    chk("full_nobypass", 64'(pushes), 64'd17);
    chk("full_reopen", 64'(tready_o), 64'd1);
    cycle();
    drain("fill_drain");
    chk("fill_pops", 64'(pops), 64'd17);

    // continuous streaming
    pops = 0;
    for (int k = 0; k < 100; k++) begin
      tvalid_i     = 1'b1;
      pkt_tready_i = 1'b1;
      tdata_i      = 64'h100 + 64'(k);
      if (k > 0) chk("cont_vld", 64'(pkt_tvalid_o), 64'd1);
      chk("cont_rdy", 64'(tready_o), 64'd1);
      cycle();
    end
    chk("cont_pops", 64'(pops), 64'd99);
    drain("cont_drain");
    chk("cont_total", 64'(pops), 64'd100);

    // random handshakes
    begin
      int start = pushes;
      int guard = 0;
      while (pushes - start < 1000 && guard < 20000) begin
        tvalid_i     = 1'($urandom_range(0, 1));
        pkt_tready_i = 1'($urandom_range(0, 1));
        tdata_i      = {$urandom, $urandom};
        cycle();
        guard++;
      end
      chk("rand_pushes", 64'(pushes - start), 64'd1000);
      drain("rand_drain");
    end

    // reset with stored beats
    pkt_tready_i = 1'b0;
    tvalid_i     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tdata_i = 64'hDEAD_0000 + 64'(k);
      cycle();
    end
    chk("pre_rst_vld", 64'(pkt_tvalid_o), 64'd1);
    tvalid_i = 1'b0;
    rst_ni   = 1'b0;
    #1;
    chk("mid_rst_rdy", 64'(tready_o), 64'd0);
    chk("mid_rst_vld", 64'(pkt_tvalid_o), 64'd0);
    cycle();
    sb_q.delete();
    hold_vld = 1'b0;
    rst_ni   = 1'b1;
    #1;
    chk("post_rst_rdy", 64'(tready_o), 64'd1);
    chk("post_rst_vld", 64'(pkt_tvalid_o), 64'd0);
    tvalid_i = 1'b1;
    tdata_i  = 64'h0000_0ABC;
    cycle();
    tvalid_i = 1'b0;
    chk("post_rst_head", lanes(), 64'h0000_0ABC);
    drain("post_rst_drain");

    // push and pop together at count 1
    tvalid_i     = 1'b1;
    pkt_tready_i = 1'b0;
    tdata_i      = 64'hAAAA_5555_0000_0001;
    cycle();
    tdata_i      = 64'hBBBB_6666_0000_0002;
    pkt_tready_i = 1'b1;
    cycle();
    tvalid_i     = 1'b0;
    pkt_tready_i = 1'b0;
    chk("pp_head", lanes(), 64'hBBBB_6666_0000_0002);
    cycle();
    chk("pp_still_vld", 64'(pkt_tvalid_o), 64'd1);
    chk("pp_rdy", 64'(tready_o), 64'd1);
    drain("pp_drain");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
